// File: rtl/cla_pkg.sv
// cla_pkg: shared op encodings, FSM states and nibble saturation constants
package cla_pkg;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SADD = 2'b10;
  localparam logic [1:0] OP_PADD = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] SAT_POS = 4'h7;
  localparam logic [3:0] SAT_NEG = 4'h8;
endpackage

// File: rtl/cla_slice4.sv
// cla_slice4: combinational 4-bit carry-look-ahead group
// ports: a4/b4/cin in; s4 sum nibble, cout carry out, g/p group generate/propagate,
//        lane_ovf signed overflow of this nibble taken on its own
module cla_slice4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout,
  output logic       g,
  output logic       p,
  output logic       lane_ovf
);
  logic [3:0] gi, pi, c;
  assign gi = a4 & b4;
  assign pi = a4 ^ b4;
  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin);
  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;
  assign cout = g | (p & cin);
  assign s4 = pi ^ c;
  assign lane_ovf = (a4[3] == b4[3]) & (s4[3] != a4[3]);
endmodule

// File: rtl/cla_addsub_seq.sv
// cla_addsub_seq: multi-cycle add/sub/saturating/packed-nibble adder, one CLA group per clock
// ports: clk, rst (async high); in_valid/in_ready + a, b, op accept side;
//        out_valid/out_ready + sum, flag_z, flag_n, flag_v result side
module cla_addsub_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);
  localparam int NG = WIDTH / 4;
  localparam int IW = NG > 1 ? $clog2(NG) : 1;
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_addsub_seq: WIDTH must be a multiple of 4 and at least 4");
  end
  state_t st;
  logic [WIDTH-1:0] a_r, b_r, raw, raw_nx, fin, mask;
  logic [1:0] op_r;
  logic [IW-1:0] idx;
  logic carry, lsat, cin, cout, gg, pp, lovf, vf, last, msb, unused_gp;
  logic [3:0] a4, b4, s4, nib;
  assign a4 = 4'(a_r >> {idx, 2'b00});
  assign b4 = 4'(b_r >> {idx, 2'b00});
  assign cin = (op_r == OP_PADD) ? 1'b0 : carry;
  cla_slice4 u_slice (
    .a4(a4), .b4(b4), .cin(cin), .s4(s4), .cout(cout), .g(gg), .p(pp), .lane_ovf(lovf)
  );
  assign unused_gp = gg ^ pp;
  // packed lanes saturate in place so the raw register already holds the final lane value
  assign nib = (op_r == OP_PADD && lovf) ? (a4[3] ? SAT_NEG : SAT_POS) : s4;
  assign mask = WIDTH'(4'hF) << {idx, 2'b00};
  assign raw_nx = (raw & ~mask) | (WIDTH'(nib) << {idx, 2'b00});
  assign last = idx == IW'(NG - 1);
  assign msb = a_r[WIDTH-1];
  // b_r is already inverted for SUB, so one overflow rule covers every full-width mode
  assign vf = (msb == b_r[WIDTH-1]) & (raw_nx[WIDTH-1] != msb);
  assign fin = (op_r == OP_SADD && vf) ? {msb, {(WIDTH-1){~msb}}} : raw_nx;
  assign in_ready = (st == IDLE) & ~rst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      a_r <= '0;
      b_r <= '0;
      raw <= '0;
      op_r <= OP_ADD;
      idx <= '0;
      carry <= 1'b0;
      lsat <= 1'b0;
      sum <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= (op == OP_SUB) ? ~b : b;
          op_r <= op;
          carry <= op == OP_SUB;
          idx <= '0;
          lsat <= 1'b0;
          st <= BUSY;
        end
        BUSY: begin
          raw <= raw_nx;
          carry <= cout;
          idx <= idx + 1'b1;
          lsat <= lsat | lovf;
          if (last) begin
            st <= DONE;
            sum <= fin;
            flag_z <= fin == '0;
            flag_n <= fin[WIDTH-1];
            flag_v <= (op_r == OP_PADD) ? (lsat | lovf) : vf;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_addsub_seq.sv
// tb_cla_addsub_seq: directed self-checking bench for cla_addsub_seq at WIDTH 16, 8 and 4
module tb_cla_addsub_seq;
  import cla_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [1:0] op;
  logic ordy;
  logic iv, ir, ov, z, n, v;
  logic [15:0] a, b, sum;
  logic iv8, ir8, ov8, z8, n8, v8;
  logic [7:0] a8, b8, sum8;
  logic iv4, ir4, ov4, z4, n4, v4;
  logic [3:0] a4, b4, sum4;
  int checks = 0;
  int failures = 0;
  cla_addsub_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .op(op),
    .out_valid(ov), .out_ready(ordy), .sum(sum), .flag_z(z), .flag_n(n), .flag_v(v)
  );
  cla_addsub_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op),
    .out_valid(ov8), .out_ready(ordy), .sum(sum8), .flag_z(z8), .flag_n(n8), .flag_v(v8)
  );
  cla_addsub_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .op(op),
    .out_valid(ov4), .out_ready(ordy), .sum(sum4), .flag_z(z4), .flag_n(n4), .flag_v(v4)
  );
  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic [2:0]  f;
  } vec_t;
  task automatic issue16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, output int lat);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    a = ~x;
    b = ~y;
    lat = 0;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic take;
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ir !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b want=0", ir); end
    checks++;
    if ({ov, sum, z, n, v} !== 20'h0) begin failures++; $display("FAIL reset_outputs got ov=%b sum=%h znv=%b%b%b want all 0", ov, sum, z, n, v); end
    checks++;
    if ({ov8, sum8, ov4, sum4} !== 14'h0) begin failures++; $display("FAIL reset_small got ov8=%b sum8=%h ov4=%b sum4=%h want 0", ov8, sum8, ov4, sum4); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ir, ir8, ir4} !== 3'b111) begin failures++; $display("FAIL reset_release_in_ready got=%b want=111", {ir, ir8, ir4}); end
  endtask
  task automatic test_arith;
    vec_t vt [11];
    int lat;
    vt[0]  = '{OP_ADD,  16'h1234, 16'h0FFF, 16'h2233, 3'b000};
    vt[1]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 3'b100};
    vt[2]  = '{OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 3'b010};
    vt[3]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 3'b001};
    vt[4]  = '{OP_SUB,  16'h1234, 16'h1234, 16'h0000, 3'b100};
    vt[5]  = '{OP_SADD, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001};
    vt[6]  = '{OP_SADD, 16'h8000, 16'hFFFF, 16'h8000, 3'b011};
    vt[7]  = '{OP_SADD, 16'h0001, 16'hFFFF, 16'h0000, 3'b100};
    vt[8]  = '{OP_PADD, 16'h7777, 16'h1119, 16'h7770, 3'b001};
    vt[9]  = '{OP_PADD, 16'h8888, 16'h8888, 16'h8888, 3'b011};
    vt[10] = '{OP_PADD, 16'h1234, 16'h1111, 16'h2345, 3'b000};
    for (int i = 0; i < 11; i++) begin
      issue16(vt[i].op, vt[i].a, vt[i].b, lat);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL arith%0d_latency got=%0d want=4", i, lat); end
      checks++;
      if (sum !== vt[i].s) begin failures++; $display("FAIL arith%0d_sum got=%h want=%h", i, sum, vt[i].s); end
      checks++;
      if ({z, n, v} !== vt[i].f) begin failures++; $display("FAIL arith%0d_flags znv got=%b%b%b want=%b", i, z, n, v, vt[i].f); end
      take();
    end
  endtask
  task automatic test_backpressure;
    int lat;
    int late;
    issue16(OP_SUB, 16'h0005, 16'h0007, lat);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        op = OP_ADD;
        a = 16'h0001;
        b = 16'h0001;
        iv = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({ov, ir, sum, z, n, v} !== {2'b10, 16'hFFFE, 3'b010}) begin
        failures++;
        $display("FAIL hold%0d got ov=%b ir=%b sum=%h znv=%b%b%b want ov=1 ir=0 sum=fffe znv=010", c, ov, ir, sum, z, n, v);
      end
    end
    ordy = 1'b1;
    iv = 1'b0;
    @(negedge clk);
    ordy = 1'b0;
    checks++;
    if ({ov, ir, sum, z, n, v} !== {2'b01, 16'hFFFE, 3'b010}) begin
      failures++;
      $display("FAIL release got ov=%b ir=%b sum=%h znv=%b%b%b want ov=0 ir=1 sum=fffe znv=010", ov, ir, sum, z, n, v);
    end
    late = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov) late++;
    end
    checks++;
    if (late !== 0) begin failures++; $display("FAIL ignored_beat got out_valid cycles=%0d want=0", late); end
  endtask
  task automatic test_reset_mid_busy;
    int lat;
    int late;
    @(negedge clk);
    op = OP_ADD;
    a = 16'hFFFF;
    b = 16'hFFFF;
    iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ov, ir, sum, z, n, v} !== 21'h0) begin
      failures++;
      $display("FAIL abort got ov=%b ir=%b sum=%h znv=%b%b%b want all 0", ov, ir, sum, z, n, v);
    end
    @(negedge clk);
    rst = 1'b0;
    late = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov) late++;
    end
    checks++;
    if (late !== 0) begin failures++; $display("FAIL abort_no_partial got out_valid cycles=%0d want=0", late); end
    issue16(OP_ADD, 16'h0001, 16'h0001, lat);
    checks++;
    if ({lat == 4, sum, z, n, v} !== {1'b1, 16'h0002, 3'b000}) begin
      failures++;
      $display("FAIL post_reset_add got lat=%0d sum=%h znv=%b%b%b want lat=4 sum=0002 znv=000", lat, sum, z, n, v);
    end
    take();
  endtask
  task automatic test_w8;
    int lat;
    @(negedge clk);
    op = OP_ADD;
    a8 = 8'h7F;
    b8 = 8'h01;
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL w8_latency got=%0d want=2", lat); end
    checks++;
    if ({sum8, z8, n8, v8} !== {8'h80, 3'b011}) begin
      failures++;
      $display("FAIL w8_add got sum=%h znv=%b%b%b want sum=80 znv=011", sum8, z8, n8, v8);
    end
    take();
  endtask
  task automatic test_w4;
    int lat;
    logic [1:0] ops [2];
    logic [3:0] xa [2];
    logic [3:0] ws [2];
    logic [2:0] wf [2];
    ops = '{OP_SADD, OP_PADD};
    xa = '{4'h7, 4'h8};
    ws = '{4'h7, 4'h8};
    wf = '{3'b001, 3'b011};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op = ops[i];
      a4 = xa[i];
      b4 = xa[i] == 4'h7 ? 4'h1 : 4'h8;
      iv4 = 1'b1;
      @(negedge clk);
      iv4 = 1'b0;
      lat = 0;
      while (!ov4 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL w4_%0d_latency got=%0d want=1", i, lat); end
      checks++;
      if ({sum4, z4, n4, v4} !== {ws[i], wf[i]}) begin
        failures++;
        $display("FAIL w4_%0d_result got sum=%h znv=%b%b%b want sum=%h znv=%b", i, sum4, z4, n4, v4, ws[i], wf[i]);
      end
      take();
    end
  endtask
  initial begin
    op = OP_ADD;
    ordy = 1'b0;
    iv = 1'b0;
    a = '0;
    b = '0;
    iv8 = 1'b0;
    a8 = '0;
    b8 = '0;
    iv4 = 1'b0;
    a4 = '0;
    b4 = '0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_busy();
    test_w8();
    test_w4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
